gpio_bcd_display: RTL and testbench
===================================

GPIO_BCD_DISPLAY -- requirements
Module: gpio_bcd_display

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named `clk` and `rst`.
REQ-002 `clk`  input  1  rising-edge clock, shared with the CPU.
REQ-003 `rst`  input  1  synchronous active-high reset, sampled on `posedge clk` only.
REQ-004 `gpio_out`  input  32  unsigned value driven by the CPU GPIO output register.
REQ-005 `hex0`..`hex7`  output  7 each  active-low segments {g,f,e,d,c,b,a}; `hex0` is the least significant decimal digit.
REQ-006 `ovf`  output  1  high when the displayed value is >= 100_000_000.
REQ-007 `busy`  output  1  high while a conversion is in progress.

Function
REQ-008 The block SHALL keep `src_q[31:0]`, the last value accepted for conversion.
REQ-009 A conversion SHALL start when the state is IDLE and `gpio_out != src_q`; `gpio_out` is latched into `src_q` and into the shift register on that edge.
REQ-010 The state machine SHALL have the states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on start.
- SHIFT -> DONE after 32 SHIFT cycles, counted by a 5-bit counter from 0 to 31.
- DONE -> IDLE unconditionally.
REQ-011 Each SHIFT cycle SHALL first add 3 to every BCD nibble that is >= 5, then shift {bcd[39:0], bin[31:0]} left by one (double-dabble algorithm).
REQ-012 The BCD register SHALL be 40 bits (10 digits) and SHALL never overflow for any 32-bit input.
REQ-013 Latency: if the start edge is N, outputs SHALL update on edge N+33 (the DONE cycle) and `busy` SHALL fall on that same edge.
REQ-014 `busy` SHALL be high in SHIFT and DONE and low in IDLE.
REQ-015 All display outputs SHALL update atomically on the DONE edge and hold their values at all other times.
REQ-016 Each digit SHALL be decoded with the standard 0-9 patterns (for example 0 = 7'b1000000, 9 = 7'b0010000).
REQ-017 Leading-zero blanking SHALL apply: every digit above the most significant nonzero digit among digits 0-7 drives 7'b1111111, and `hex0` is never blanked.
REQ-018 `ovf` SHALL equal (BCD digit 8 != 0) OR (BCD digit 9 != 0); digits 8 and 9 are otherwise not displayed.
REQ-019 With `ovf` high, digits 0-7 SHALL still display unblanked-zero-correctly, meaning no blanking is applied while `ovf` = 1.
REQ-020 A change of `gpio_out` during SHIFT or DONE SHALL NOT disturb the current conversion.
- The change is picked up in the next IDLE cycle by the REQ-009 compare.
- Only the final stable value is guaranteed to be displayed.
REQ-021 If `gpio_out` returns to `src_q` before IDLE, no new conversion SHALL start.
REQ-022 Each completed conversion SHALL spend exactly one cycle in IDLE before the next start; the minimum start-to-start interval is 34 cycles.

Reset
REQ-023 On `rst`, the block SHALL set:
- state = IDLE, counter = 0, `src_q` = 0, shift registers = 0;
- `hex0` = 7'b1000000, `hex1`..`hex7` = 7'b1111111;
- `ovf` = 0, `busy` = 0.
REQ-024 A reset asserted mid-conversion SHALL abort the conversion with no output update and apply the REQ-023 values on that edge.
REQ-025 After reset is released, if `gpio_out` is nonzero a conversion SHALL start on the first non-reset edge.

Structure
REQ-026 A shared package (`gpio_pkg`) SHALL hold:
- the state enum {IDLE, SHIFT, DONE};
- `NDIGITS` = 10 and `NSHOW` = 8;
- `SEG_BLANK` = 7'b1111111 and the digit-pattern table.
REQ-027 One sub-module, `bcd7seg`, SHALL be used: a combinational 4-bit BCD to 7-bit active-low decoder, instantiated 8 times.
REQ-028 The target size is 120-400 lines of RTL, with no inferred latches and no multi-cycle paths.

Verification
REQ-029 Reset, then hold `gpio_out` = 0 for 50 cycles: `hex0` = 1000000, `hex1`..`hex7` blank, `busy` never rises.
REQ-030 Drive `gpio_out` = 1234 at edge N:
- `busy` = 1 on N+1..N+32;
- on N+33, `hex3..hex0` show 1,2,3,4, `hex4`..`hex7` blank, `ovf` = 0.
REQ-031 Drive 99_999_999: all eight digits show 9 and `ovf` = 0. Then drive 4_294_967_295: `ovf` = 1, digits show 94967295, nothing blanked.
REQ-032 Drive 5, then change to 77 ten cycles after the start:
- the display shows 5 at the first DONE;
- a second conversion starts 1 cycle later;
- the display shows 77 34 cycles after that.
REQ-033 Assert `rst` at SHIFT count 15 of a conversion of 12345678: outputs take the reset values on that edge; after release with `gpio_out` held, 12345678 appears 34 cycles later.
REQ-034 A randomized pass of 1000 values SHALL compare every DONE update against a reference decimal model.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO-driven BCD seven-segment display.
package gpio_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int NDIGITS = 10;
  localparam int NSHOW   = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by digit value.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };
endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal codes decode to a blank digit.
module bcd7seg
  import gpio_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) seg_o = SEG_TABLE[bcd_i];
  end
endmodule

// File: rtl/gpio_bcd_display.sv
// Converts the CPU GPIO word to decimal by double-dabble (32 shift cycles) and
// drives eight blanked seven-segment digits plus an overflow flag.
module gpio_bcd_display
  import gpio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_out,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic        ovf,
  output logic        busy
);
  state_t                     state_q, state_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic [31:0]                src_q, src_d;
  logic [31:0]                bin_q, bin_d;
  logic [4*NDIGITS-1:0]       bcd_q, bcd_d;
  logic [NSHOW-1:0][6:0]      hex_q, hex_d;
  logic                       ovf_q, ovf_d;

  logic [4*NDIGITS-1:0]       bcd_adj;
  logic [NSHOW-1:0][6:0]      seg_w;
  logic [NSHOW-1:0][6:0]      disp_w;
  logic                       ovf_w;

  assign ovf_w = |bcd_q[4*NDIGITS-1:4*NSHOW];

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  for (genvar g = 0; g < NSHOW; g++) begin : g_dec
    bcd7seg u_dec (
      .bcd_i (bcd_q[4*g +: 4]),
      .seg_o (seg_w[g])
    );
  end

  // Walk down from the top digit; once a nonzero digit is seen everything
  // below it is shown. Overflow disables blanking entirely.
  always_comb begin
    logic seen;
    seen   = 1'b0;
    disp_w = '0;
    for (int i = NSHOW - 1; i >= 0; i--) begin
      seen      = seen | (bcd_q[4*i +: 4] != 4'd0);
      disp_w[i] = (seen || ovf_w || i == 0) ? seg_w[i] : SEG_BLANK;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (gpio_out != src_q) begin
          src_d   = gpio_out;
          bin_d   = gpio_out;
          bcd_d   = '0;
          cnt_d   = 5'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[4*NDIGITS-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        hex_d   = disp_w;
        ovf_d   = ovf_w;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      src_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      hex_q   <= {{(NSHOW-1){SEG_BLANK}}, SEG_TABLE[0]};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];
  assign ovf  = ovf_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_gpio_bcd_display.sv
// Directed and randomized checks of the GPIO BCD display against a decimal model.
module tb_gpio_bcd_display;
  logic        clk;
  logic        rst;
  logic [31:0] gpio_out;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        ovf;
  logic        busy;

  int tests = 0;
  int fails = 0;

  gpio_bcd_display dut (
    .clk      (clk),
    .rst      (rst),
    .gpio_out (gpio_out),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5),
    .hex6     (hex6),
    .hex7     (hex7),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // {ovf, hex7..hex0} expected for a displayed value
  function automatic logic [56:0] model(input logic [31:0] v);
    logic [3:0]  dig [10];
    logic [31:0] t;
    logic        ov;
    int          top;
    logic [56:0] r;
    t = v;
    for (int i = 0; i < 10; i++) begin
      dig[i] = 4'(t % 10);
      t      = t / 10;
    end
    ov  = (dig[8] != 0) || (dig[9] != 0);
    top = 0;
    for (int i = 0; i < 8; i++) if (dig[i] != 0) top = i;
    r = '0;
    r[56] = ov;
    for (int i = 0; i < 8; i++)
      r[7*i +: 7] = (ov || i <= top) ? pat(dig[i]) : 7'b1111111;
    return r;
  endfunction

  function automatic logic [56:0] observed();
    return {ovf, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive v just before the start edge, then follow it to the DONE edge.
  task automatic run_conv(input logic [31:0] v, input string tag, input bit chk_busy);
    gpio_out = v;
    step();
    for (int i = 1; i <= 32; i++) begin
      step();
      if (chk_busy) check({tag, "_busy_hi"}, 64'(busy), 64'd1);
    end
    step();
    check({tag, "_busy_lo"}, 64'(busy), 64'd0);
    check({tag, "_disp"}, 64'(observed()), 64'(model(v)));
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] v;

    rst      = 1'b1;
    gpio_out = 32'd0;
    step();
    step();
    check("reset_disp", 64'(observed()), 64'(model(32'd0)));
    check("reset_busy", 64'(busy), 64'd0);

    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      check("idle_zero_busy", 64'(busy), 64'd0);
    end
    check("idle_zero_disp", 64'(observed()), 64'(model(32'd0)));

    run_conv(32'd1234, "v1234", 1'b1);
    run_conv(32'd99_999_999, "v99999999", 1'b0);
    run_conv(32'd4_294_967_295, "vmax", 1'b0);
    run_conv(32'd100_000_000, "v1e8", 1'b0);
    run_conv(32'd1_000_000, "v1e6", 1'b0);
    run_conv(32'd0, "vzero", 1'b0);

    // Input changes mid-conversion: first result still the old value.
    gpio_out = 32'd5;
    step();
    for (int i = 0; i < 10; i++) step();
    gpio_out = 32'd77;
    for (int i = 0; i < 23; i++) step();
    check("chg_first_disp", 64'(observed()), 64'(model(32'd5)));
    check("chg_first_busy", 64'(busy), 64'd0);
    step();
    check("chg_restart_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 32; i++) step();
    check("chg_hold_disp", 64'(observed()), 64'(model(32'd5)));
    step();
    check("chg_second_disp", 64'(observed()), 64'(model(32'd77)));

    // Input wanders and returns before IDLE: no further conversion.
    gpio_out = 32'd300;
    step();
    for (int i = 0; i < 5; i++) step();
    gpio_out = 32'd301;
    for (int i = 0; i < 5; i++) step();
    gpio_out = 32'd300;
    for (int i = 0; i < 23; i++) step();
    check("ret_disp", 64'(observed()), 64'(model(32'd300)));
    step();
    check("ret_no_restart", 64'(busy), 64'd0);

    // Reset in the middle of a conversion.
    gpio_out = 32'd12_345_678;
    step();
    for (int i = 0; i < 15; i++) step();
    rst = 1'b1;
    step();
    check("midrst_disp", 64'(observed()), 64'(model(32'd0)));
    check("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();
    check("midrst_restart", 64'(busy), 64'd1);
    for (int i = 0; i < 32; i++) step();
    check("midrst_hold_disp", 64'(observed()), 64'(model(32'd0)));
    step();
    check("midrst_final_disp", 64'(observed()), 64'(model(32'd12_345_678)));

    prev = 32'd12_345_678;
    for (int n = 0; n < 1000; n++) begin
      v = $urandom() >> $urandom_range(0, 31);
      if (v == prev) v = v + 32'd1;
      run_conv(v, "rand", 1'b0);
      prev = v;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
